mips_multicycle_cu: RTL and testbench

Multicycle MIPS control unit: a clocked state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the same datapath selects (`sm1`..`sm5`, `ALUOp`) used by the single-cycle datapath, and adds PC/IR write enables, a memory-ready handshake and a multi-cycle multiply/divide wait. It sits between the instruction register/`zero` flag and the multicycle datapath.

---
 rtl/mips_multicycle_cu_if.sv | 40 ++++
 rtl/mips_multicycle_cu.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_cu.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_cu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_cu_if                                                |
// | Control-unit <-> datapath signal bundle for the multicycle MIPS CU.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mips_multicycle_cu_if;
  logic       zero;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       memReady;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       pcWrite;
  logic       irWrite;
  logic       mdStart;
  logic       mdBusy;
  logic [1:0] sm1;
  logic [1:0] sm2;
  logic [1:0] sm3;
  logic [1:0] sm4;
  logic [1:0] sm5;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic       illegal;

  modport master (
    output zero, opcode, func, memReady,
    input  regWrite, memRead, memWrite, pcWrite, irWrite, mdStart, mdBusy,
    input  sm1, sm2, sm3, sm4, sm5, ALUOp, state, illegal
  );

  modport slave (
    input  zero, opcode, func, memReady,
    output regWrite, memRead, memWrite, pcWrite, irWrite, mdStart, mdBusy,
    output sm1, sm2, sm3, sm4, sm5, ALUOp, state, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_cu                                                   |
// | Multicycle MIPS control FSM; define MIPS_CU_MULDIV_EN for MDWAIT.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mips_multicycle_cu #(
  parameter int MD_CYCLES = 32
) (
  input wire clk,
  input wire rst,
  mips_multicycle_cu_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_IDLE   = 3'd6
  } state_t;

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_slti = 6'b001010;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_lui  = 6'b001111;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_bne  = 6'b000101;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_jal  = 6'b000011;
  localparam logic [5:0] c_fn_jr   = 6'b001000;
  localparam logic [5:0] c_fn_mult = 6'b011000;
  localparam logic [5:0] c_fn_div  = 6'b011010;

  if (MD_CYCLES < 1) begin : g_md_cycles_check
    $error("MD_CYCLES must be at least 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [5:0] r_func;
  logic       r_illegal;
  logic       w_dec_ok;
  logic       w_jr;
  logic       w_md;
  logic       w_hold;
  logic [9:0] w_sel;

  always_comb begin
    w_dec_ok = 1'b0;
    case (bus.opcode)
      c_op_r, c_op_addi, c_op_slti, c_op_lw, c_op_sw,
      c_op_lui, c_op_beq, c_op_bne, c_op_j, c_op_jal: w_dec_ok = 1'b1;
      default:                                        w_dec_ok = 1'b0;
    endcase
  end

  assign w_jr   = (r_op == c_op_r) && (r_func == c_fn_jr);
  assign w_md   = (r_op == c_op_r) && ((r_func == c_fn_mult) || (r_func == c_fn_div));
  assign w_hold = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  // Class selects packed as {ALUOp, sm1, sm2, sm3, sm4}
  always_comb begin
    w_sel = '0;
    case (r_op)
      c_op_r:             w_sel = 10'b00_01_01_00_01;
      c_op_addi:          w_sel = 10'b01_00_01_01_01;
      c_op_slti:          w_sel = 10'b11_00_01_01_01;
      c_op_lw:            w_sel = 10'b01_00_01_01_00;
      c_op_sw:            w_sel = 10'b01_00_00_01_00;
      c_op_lui:           w_sel = 10'b00_00_01_00_01;
      c_op_beq, c_op_bne: w_sel = 10'b10_00_00_00_00;
      c_op_j:             w_sel = 10'b01_00_00_00_00;
      c_op_jal:           w_sel = 10'b01_10_00_00_00;
      default:            w_sel = '0;
    endcase
  end

`ifdef MIPS_CU_MULDIV_EN
  localparam int c_cnt_w = $clog2(MD_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_md_load = c_cnt_w'(MD_CYCLES - 1);

  logic [c_cnt_w-1:0] r_md_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md_cnt <= '0;
    end else if ((r_state == S_EXEC) && w_md) begin
      r_md_cnt <= c_md_load;
    end else if ((r_state == S_MDWAIT) && (r_md_cnt != '0)) begin
      r_md_cnt <= r_md_cnt - c_cnt_w'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_func    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op   <= bus.opcode;
        r_func <= bus.func;
        if (!w_dec_ok) r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.regWrite = 1'b0;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.pcWrite  = 1'b0;
    bus.irWrite  = 1'b0;
    bus.mdStart  = 1'b0;
    bus.mdBusy   = 1'b0;
    bus.sm5      = 2'b00;
    {bus.ALUOp, bus.sm1, bus.sm2, bus.sm3, bus.sm4} = '0;
    if (w_hold) {bus.ALUOp, bus.sm1, bus.sm2, bus.sm3, bus.sm4} = w_sel;

    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.memRead = 1'b1;
        if (bus.memReady) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: w_next = w_dec_ok ? S_EXEC : S_FETCH;
      S_EXEC: begin
        w_next = S_WB;
        if (r_op == c_op_beq) begin
          bus.pcWrite = bus.zero;
          bus.sm5     = 2'b01;
          w_next      = S_FETCH;
        end else if (r_op == c_op_bne) begin
          bus.pcWrite = !bus.zero;
          bus.sm5     = 2'b01;
          w_next      = S_FETCH;
        end else if ((r_op == c_op_j) || (r_op == c_op_jal)) begin
          bus.pcWrite  = 1'b1;
          bus.sm5      = 2'b10;
          bus.regWrite = (r_op == c_op_jal);
          w_next       = S_FETCH;
        end else if (w_jr) begin
          bus.pcWrite = 1'b1;
          bus.sm5     = 2'b11;
          w_next      = S_FETCH;
        end else if (w_md) begin
`ifdef MIPS_CU_MULDIV_EN
          bus.mdStart = 1'b1;
          w_next      = S_MDWAIT;
`else
          w_next      = S_FETCH;
`endif
        end else if ((r_op == c_op_lw) || (r_op == c_op_sw)) begin
          w_next = S_MEM;
        end
      end
      S_MEM: begin
        bus.memRead  = (r_op == c_op_lw);
        bus.memWrite = (r_op != c_op_lw);
        if (bus.memReady) w_next = (r_op == c_op_lw) ? S_WB : S_FETCH;
      end
      S_WB: begin
        bus.regWrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_MDWAIT: begin
`ifdef MIPS_CU_MULDIV_EN
        bus.mdBusy = 1'b1;
        if (r_md_cnt == '0) w_next = S_FETCH;
`else
        w_next = S_FETCH;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.state   = r_state;
  assign bus.illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_multicycle_cu                                                |
// | Self-checking bench: directed table plus random instruction stream.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mips_multicycle_cu;
  localparam int MD = 4;
`ifdef MIPS_CU_MULDIV_EN
  localparam int MD_CPI = MD + 3;
`else
  localparam int MD_CPI = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_cu_if bus ();
  mips_multicycle_cu #(.MD_CYCLES(MD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic [2:0] st;
    logic rw, mr, mw, pw, iw, ms, mb;
    logic [1:0] s1, s2, s3, s4, s5, alu;
    logic ill;
  } out_t;

  typedef struct packed {
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    out_t       e;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fs;
    int         ms;
    int         cyc;
    int         rw;
    string      name;
  } vec_t;

  cyc_t q[$];
  vec_t vq[$];
  bit   m_ill;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.st = bus.state;   s.rw = bus.regWrite; s.mr = bus.memRead; s.mw = bus.memWrite;
    s.pw = bus.pcWrite; s.iw = bus.irWrite;  s.ms = bus.mdStart; s.mb = bus.mdBusy;
    s.s1 = bus.sm1; s.s2 = bus.sm2; s.s3 = bus.sm3; s.s4 = bus.sm4; s.s5 = bus.sm5;
    s.alu = bus.ALUOp; s.ill = bus.illegal;
    return s;
  endfunction

  function automatic bit supported(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
      6'b001111, 6'b000100, 6'b000101, 6'b000010, 6'b000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {ALUOp, sm1, sm2, sm3, sm4} by instruction class
  function automatic logic [9:0] sel_of(input logic [5:0] op);
    case (op)
      6'b000000:            return {2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
      6'b001000:            return {2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
      6'b001010:            return {2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
      6'b100011:            return {2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
      6'b101011:            return {2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
      6'b001111:            return {2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
      6'b000100, 6'b000101: return {2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      6'b000010:            return {2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      6'b000011:            return {2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
      default:              return '0;
    endcase
  endfunction

  function automatic out_t blank(input logic [2:0] st, input logic [5:0] op, input bit sel);
    out_t e = '0;
    e.st  = st;
    e.ill = m_ill;
    if (sel) {e.alu, e.s1, e.s2, e.s3, e.s4} = sel_of(op);
    return e;
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input out_t e);
    cyc_t c;
    c.mr = mr; c.op = op; c.fn = fn; c.z = z; c.e = e;
    q.push_back(c);
  endtask

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  // Expected cycle-by-cycle trace of one instruction; opcode/func are only
  // presented in DECODE, garbage elsewhere.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fs, input int ms);
    out_t e;
    bit   isr, jr, md, lw, sw, wb;
    for (int k = 0; k < fs; k++) begin
      e = blank(3'd0, op, 1'b0); e.mr = 1'b1;
      push(1'b0, rnd6(), rnd6(), 1'($urandom), e);
    end
    e = blank(3'd0, op, 1'b0); e.mr = 1'b1; e.iw = 1'b1; e.pw = 1'b1;
    push(1'b1, rnd6(), rnd6(), 1'($urandom), e);
    e = blank(3'd1, op, 1'b0);
    push(1'($urandom), op, fn, 1'($urandom), e);
    if (!supported(op)) begin
      m_ill = 1'b1;
      return;
    end
    isr = (op == 6'b000000);
    jr  = isr && (fn == 6'b001000);
    md  = isr && (fn == 6'b011000 || fn == 6'b011010);
    lw  = (op == 6'b100011);
    sw  = (op == 6'b101011);
    wb  = lw || (isr && !jr && !md) || op == 6'b001000 || op == 6'b001010 || op == 6'b001111;
    e = blank(3'd2, op, 1'b1);
    if (op == 6'b000100)      begin e.pw = z;    e.s5 = 2'b01; end
    else if (op == 6'b000101) begin e.pw = !z;   e.s5 = 2'b01; end
    else if (op == 6'b000010) begin e.pw = 1'b1; e.s5 = 2'b10; end
    else if (op == 6'b000011) begin e.pw = 1'b1; e.s5 = 2'b10; e.rw = 1'b1; end
    else if (jr)              begin e.pw = 1'b1; e.s5 = 2'b11; end
`ifdef MIPS_CU_MULDIV_EN
    else if (md)              e.ms = 1'b1;
`endif
    push(1'($urandom), rnd6(), rnd6(), z, e);
    if (lw || sw) begin
      for (int k = 0; k <= ms; k++) begin
        e = blank(3'd3, op, 1'b1); e.mr = lw; e.mw = sw;
        push(k == ms, rnd6(), rnd6(), 1'($urandom), e);
      end
    end
    if (wb) begin
      e = blank(3'd4, op, 1'b1); e.rw = 1'b1;
      push(1'($urandom), rnd6(), rnd6(), 1'($urandom), e);
    end
`ifdef MIPS_CU_MULDIV_EN
    if (md) begin
      for (int k = 0; k < MD; k++) begin
        e = blank(3'd5, op, 1'b0); e.mb = 1'b1;
        push(1'($urandom), rnd6(), rnd6(), 1'($urandom), e);
      end
    end
`endif
  endtask

  // Apply up to 'limit' queued cycles; cpi is the trace length if the DUT
  // is back in FETCH afterwards, else -1.
  task automatic run_q(input string name, input int limit, output int rw_seen, output int cpi);
    int n;
    cyc_t c;
    n = q.size();
    rw_seen = 0;
    for (int i = 0; i < n; i++) begin
      c = q.pop_front();
      if (i < limit) begin
        bus.memReady = c.mr; bus.opcode = c.op; bus.func = c.fn; bus.zero = c.z;
        @(negedge clk);
        check($sformatf("%s cyc%0d", name, i), 32'(sample()), 32'(c.e));
        rw_seen += int'(bus.regWrite);
        @(posedge clk); #1;
      end
    end
    cpi = (bus.state == 3'd0) ? n : -1;
  endtask

  task automatic add(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int fs, input int ms, input int cyc, input int rw);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.fs = fs; v.ms = ms; v.cyc = cyc; v.rw = rw;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    out_t e;
    int   rw, cpi, sel;
    logic [5:0] op, fn;

    add("addi",    6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1);
    add("lw_wait", 6'b100011, 6'b000000, 1'b0, 0, 2, 7, 1);
    add("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, 3, 0);
    add("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, 3, 0);
    add("bne_z1",  6'b000101, 6'b000000, 1'b1, 0, 0, 3, 0);
    add("bne_z0",  6'b000101, 6'b000000, 1'b0, 0, 0, 3, 0);
    add("jal",     6'b000011, 6'b000000, 1'b0, 0, 0, 3, 1);
    add("j",       6'b000010, 6'b000000, 1'b1, 0, 0, 3, 0);
    add("jr",      6'b000000, 6'b001000, 1'b0, 0, 0, 3, 0);
    add("add_fst", 6'b000000, 6'b100000, 1'b0, 1, 0, 5, 1);
    add("sw_wait", 6'b101011, 6'b000000, 1'b0, 0, 1, 5, 0);
    add("slti",    6'b001010, 6'b000000, 1'b0, 0, 0, 4, 1);
    add("lui",     6'b001111, 6'b000000, 1'b0, 0, 0, 4, 1);
    add("mult",    6'b000000, 6'b011000, 1'b0, 0, 0, MD_CPI, 0);
    add("div",     6'b000000, 6'b011010, 1'b0, 0, 0, MD_CPI, 0);
    add("illegal", 6'b111111, 6'b000000, 1'b0, 0, 0, 2, 0);
    add("add_ill", 6'b000000, 6'b100010, 1'b0, 0, 0, 4, 1);

    bus.memReady = 1'b0; bus.opcode = '0; bus.func = '0; bus.zero = 1'b0;
    m_ill = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    e = '0; e.st = 3'd6;
    check("reset state", 32'(sample()), 32'(e));
    rst = 1'b1;
    bus.memReady = 1'b1;
    @(negedge clk);
    check("idle after reset", 32'(sample()), 32'(e));
    @(posedge clk); #1;

    foreach (vq[k]) begin
      build(vq[k].op, vq[k].fn, vq[k].z, vq[k].fs, vq[k].ms);
      run_q(vq[k].name, q.size(), rw, cpi);
      check({vq[k].name, " regWrite count"}, 32'(rw), 32'(vq[k].rw));
      check({vq[k].name, " cycles"}, 32'(cpi), 32'(vq[k].cyc));
    end
    check("illegal sticky", 32'(bus.illegal), 32'd1);

    // Async reset in the middle of a stalled lw MEM phase
    build(6'b100011, 6'b000000, 1'b0, 0, 3);
    run_q("lw_rst", 4, rw, cpi);
    bus.memReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    e = '0; e.st = 3'd6;
    check("reset mid MEM", 32'(sample()), 32'(e));
    m_ill = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("idle after mid reset", 32'(sample()), 32'(e));
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 1:    op = 6'b000000;
        2:       op = 6'b001000;
        3:       op = 6'b001010;
        4:       op = 6'b100011;
        5:       op = 6'b101011;
        6:       op = 6'b001111;
        7:       op = 6'b000100;
        8:       op = 6'b000101;
        9:       op = 6'b000010;
        10:      op = 6'b000011;
        default: op = rnd6();
      endcase
      case ($urandom_range(0, 4))
        0:       fn = 6'b001000;
        1:       fn = 6'b011000;
        2:       fn = 6'b011010;
        3:       fn = 6'b100000;
        default: fn = rnd6();
      endcase
      build(op, fn, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      run_q($sformatf("rand%0d op%b fn%b", n, op, fn), q.size(), rw, cpi);
      check($sformatf("rand%0d back to fetch", n), 32'(cpi >= 0), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
